host_job_arbiter: RTL and testbench

- Shares the single job-insert path (`i_input_info` / `i_insert_req` of job_decoder) between `MAX_HOST_NUMBER` host request channels.
- Uses round-robin arbitration with per-host tag credits, so no host has more than `NO_OF_TAG` jobs in flight.
- Sits upstream of top/job_decoder.
- Credits are returned from the completion pulse (`meta_data_valid`) qualified by a completing host id.

---
 rtl/host_job_arbiter_pkg.sv | 36 +++
 rtl/host_job_arbiter_rr_arbiter.sv | 43 ++++
 rtl/host_job_arbiter.sv | 181 ++++++++++++++++++
 tb/tb_host_job_arbiter.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/host_job_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// host_job_arbiter_pkg
// Shared sizing defaults and helpers for the host job arbiter slice.
//
// Configuration macros:
//   MAX_HOST_NUMBER       number of requesting hosts (default 4)
//   NO_OF_TAG             max outstanding jobs per host (default 8)
//   JOB_ARB_CREDIT_INIT   credit reload value, equal to NO_OF_TAG
//   JOB_ARB_HOST0_PRIO_EN when defined, host 0 has strict priority over the
//                         round-robin hosts (see host_job_arbiter)
//
// The first three normally come from defines.vh. The fallbacks below let the
// slice build on its own.
// -----------------------------------------------------------------------------
`ifndef MAX_HOST_NUMBER
`define MAX_HOST_NUMBER 4
`endif
`ifndef NO_OF_TAG
`define NO_OF_TAG 8
`endif
`ifndef JOB_ARB_CREDIT_INIT
`define JOB_ARB_CREDIT_INIT `NO_OF_TAG
`endif

package host_job_arbiter_pkg;

    localparam int DEF_MAX_HOST_NUMBER     = `MAX_HOST_NUMBER;
    localparam int DEF_NO_OF_TAG           = `NO_OF_TAG;
    localparam int DEF_INFO_DATA_BIT_WIDTH = 128;

    // Next round-robin position after index idx, wrapping at n.
    function automatic int rr_next(input int idx, input int n);
        return (idx >= n - 1) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/host_job_arbiter_rr_arbiter.sv
// -----------------------------------------------------------------------------
// rr_arbiter
// Purely combinational round-robin picker. The search starts at i_ptr and wraps
// modulo N. The first requesting index wins.
//
// Ports:
//   i_req        N-bit request vector
//   i_ptr        IW-bit index where the search starts
//   o_grant      one-hot grant (zero when nothing is requested)
//   o_grant_idx  index of the granted request (0 when none)
//   o_any_grant  1 when some request was granted
// -----------------------------------------------------------------------------
module rr_arbiter #(
    parameter int N  = 4,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  i_req,
    input  logic [IW-1:0] i_ptr,
    output logic [N-1:0]  o_grant,
    output logic [IW-1:0] o_grant_idx,
    output logic          o_any_grant
);

    always_comb begin
        int  idx;
        logic found;
        o_grant     = '0;
        o_grant_idx = '0;
        o_any_grant = 1'b0;
        found       = 1'b0;
        idx         = 0;
        for (int k = 0; k < N; k++) begin
            idx = (int'(i_ptr) + k) % N;
            if (!found && i_req[idx]) begin
                found          = 1'b1;
                o_grant[idx]   = 1'b1;
                o_grant_idx    = IW'(idx);
                o_any_grant    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/host_job_arbiter.sv
// -----------------------------------------------------------------------------
// host_job_arbiter
// Shares the single job_decoder insert path between MAX_HOST_NUMBER hosts using
// round-robin arbitration with per-host tag credits. A grant consumes a credit.
// A completion (i_done_valid with i_done_host_id) returns one.
//
// Optional feature macro: JOB_ARB_HOST0_PRIO_EN. When it is defined, host 0 is
// granted whenever it is eligible, and such a grant leaves the pointer alone.
// Hosts 1..N-1 keep round-robin among themselves.
//
// Ports:
//   i_clk, i_rst_n      clock; asynchronous active-low reset
//   i_req_valid/info    per-host request valid and info (host h at [h*W +: W])
//   o_req_ready         combinational per-host accept, one-hot or zero
//   o_info/o_info_req   registered job info and one-cycle insert pulse
//   o_host_id           registered index of the granted host
//   i_done_valid/host   completion pulse and the host it belongs to
//   o_credit_avail      per-host credit > 0
//   o_credit_err        sticky credit overflow / bad host id
// -----------------------------------------------------------------------------
module host_job_arbiter
    import host_job_arbiter_pkg::*;
#(
    parameter int MAX_HOST_NUMBER     = DEF_MAX_HOST_NUMBER,
    parameter int NO_OF_TAG           = DEF_NO_OF_TAG,
    parameter int INFO_DATA_BIT_WIDTH = DEF_INFO_DATA_BIT_WIDTH,
    parameter int HOST_ID_BIT_WIDTH   = $clog2(MAX_HOST_NUMBER),
    parameter int CREDIT_WIDTH        = $clog2(NO_OF_TAG + 1)
) (
    input  logic                                         i_clk,
    input  logic                                         i_rst_n,
    input  logic [MAX_HOST_NUMBER-1:0]                   i_req_valid,
    input  logic [MAX_HOST_NUMBER*INFO_DATA_BIT_WIDTH-1:0] i_req_info,
    output logic [MAX_HOST_NUMBER-1:0]                   o_req_ready,
    output logic [INFO_DATA_BIT_WIDTH-1:0]               o_info,
    output logic                                         o_info_req,
    output logic [HOST_ID_BIT_WIDTH-1:0]                 o_host_id,
    input  logic                                         i_done_valid,
    input  logic [HOST_ID_BIT_WIDTH-1:0]                 i_done_host_id,
    output logic [MAX_HOST_NUMBER-1:0]                   o_credit_avail,
    output logic                                         o_credit_err
);

    localparam int N  = MAX_HOST_NUMBER;
    localparam int W  = INFO_DATA_BIT_WIDTH;
    localparam int HW = HOST_ID_BIT_WIDTH;
    localparam int CW = CREDIT_WIDTH;
    localparam logic [CW-1:0] CREDIT_FULL = CW'(NO_OF_TAG);

    logic [CW-1:0] credit_q [N];
    logic [CW-1:0] credit_d [N];
    logic [HW-1:0] rr_ptr_q, rr_ptr_d;
    logic [W-1:0]  info_q, info_d;
    logic          info_req_q, info_req_d;
    logic [HW-1:0] host_id_q, host_id_d;
    logic          err_q, err_d;

    logic [N-1:0]  eligible;
    logic [N-1:0]  done_hit;
    logic          done_bad_id;

    logic [N-1:0]  rr_grant;
    logic [HW-1:0] rr_idx;
    logic          rr_any;

    logic [N-1:0]  grant;
    logic [HW-1:0] grant_idx;
    logic          any_grant;
    logic          ptr_update;

    genvar gi;
    generate
        for (gi = 0; gi < N; gi++) begin : g_host
            assign eligible[gi]       = i_req_valid[gi] && (credit_q[gi] != '0);
            assign o_credit_avail[gi] = (credit_q[gi] != '0);
            assign done_hit[gi]       = i_done_valid && (i_done_host_id == HW'(gi));
        end
    endgenerate

    // Only reachable when the host count is not a power of two.
    assign done_bad_id = i_done_valid && (32'(i_done_host_id) >= 32'(N));

`ifdef JOB_ARB_HOST0_PRIO_EN
    localparam logic [N-1:0] HOST0_BIT = N'(1);

    // Host 0 is removed from the rotation and handled by the override below.
    rr_arbiter #(.N(N), .IW(HW)) u_rr (
        .i_req       (eligible & ~HOST0_BIT),
        .i_ptr       (rr_ptr_q),
        .o_grant     (rr_grant),
        .o_grant_idx (rr_idx),
        .o_any_grant (rr_any)
    );

    always_comb begin
        if (eligible[0]) begin
            grant      = HOST0_BIT;
            grant_idx  = '0;
            any_grant  = 1'b1;
            ptr_update = 1'b0;
        end else begin
            grant      = rr_grant;
            grant_idx  = rr_idx;
            any_grant  = rr_any;
            ptr_update = rr_any;
        end
    end
`else
    rr_arbiter #(.N(N), .IW(HW)) u_rr (
        .i_req       (eligible),
        .i_ptr       (rr_ptr_q),
        .o_grant     (rr_grant),
        .o_grant_idx (rr_idx),
        .o_any_grant (rr_any)
    );

    always_comb begin
        grant      = rr_grant;
        grant_idx  = rr_idx;
        any_grant  = rr_any;
        ptr_update = rr_any;
    end
`endif

    // The ready signal is the grant itself. A valid host that sees ready
    // transfers in the same cycle.
    assign o_req_ready = grant;

    always_comb begin
        rr_ptr_d   = ptr_update ? HW'(rr_next(int'(grant_idx), N)) : rr_ptr_q;
        info_req_d = any_grant;
        info_d     = any_grant ? i_req_info[grant_idx*W +: W] : info_q;
        host_id_d  = any_grant ? grant_idx : host_id_q;
    end

    // A grant and a completion for the same host cancel out. A completion at
    // full credit means a tag was returned that was never handed out.
    always_comb begin
        err_d = err_q | done_bad_id;
        for (int h = 0; h < N; h++) begin
            credit_d[h] = credit_q[h];
            if (done_hit[h] && !grant[h]) begin
                if (credit_q[h] == CREDIT_FULL) begin
                    err_d = 1'b1;
                end else begin
                    credit_d[h] = credit_q[h] + CW'(1);
                end
            end else if (grant[h] && !done_hit[h]) begin
                credit_d[h] = credit_q[h] - CW'(1);
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int h = 0; h < N; h++) begin
                credit_q[h] <= CREDIT_FULL;
            end
            rr_ptr_q   <= '0;
            info_q     <= '0;
            info_req_q <= 1'b0;
            host_id_q  <= '0;
            err_q      <= 1'b0;
        end else begin
            for (int h = 0; h < N; h++) begin
                credit_q[h] <= credit_d[h];
            end
            rr_ptr_q   <= rr_ptr_d;
            info_q     <= info_d;
            info_req_q <= info_req_d;
            host_id_q  <= host_id_d;
            err_q      <= err_d;
        end
    end

    assign o_info       = info_q;
    assign o_info_req   = info_req_q;
    assign o_host_id    = host_id_q;
    assign o_credit_err = err_q;

endmodule

// File: tb/tb_host_job_arbiter.sv
// -----------------------------------------------------------------------------
// tb_host_job_arbiter
// Directed scenarios followed by random traffic. All of it is checked against
// a credit/pointer model of the arbiter kept in this bench. Four hosts are used,
// with four tags each.
// -----------------------------------------------------------------------------
module tb_host_job_arbiter;

    localparam int N   = 4;
    localparam int TAG = 4;
    localparam int W   = 128;
    localparam int HW  = 2;

    logic             clk;
    logic             rst_n;
    logic [N-1:0]     req_valid;
    logic [N*W-1:0]   req_info;
    logic [N-1:0]     req_ready;
    logic [W-1:0]     info;
    logic             info_req;
    logic [HW-1:0]    host_id;
    logic             done_valid;
    logic [HW-1:0]    done_host_id;
    logic [N-1:0]     credit_avail;
    logic             credit_err;

    host_job_arbiter #(
        .MAX_HOST_NUMBER     (N),
        .NO_OF_TAG           (TAG),
        .INFO_DATA_BIT_WIDTH (W)
    ) dut (
        .i_clk          (clk),
        .i_rst_n        (rst_n),
        .i_req_valid    (req_valid),
        .i_req_info     (req_info),
        .o_req_ready    (req_ready),
        .o_info         (info),
        .o_info_req     (info_req),
        .o_host_id      (host_id),
        .i_done_valid   (done_valid),
        .i_done_host_id (done_host_id),
        .o_credit_avail (credit_avail),
        .o_credit_err   (credit_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference state: what the arbiter should hold after the most recent edge.
    int          m_credit [N];
    int          m_ptr;
    logic [W-1:0] m_info;
    bit          m_req;
    int          m_id;
    bit          m_err;
    int          grant_count;

    int n_checks;
    int n_fail;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [N*W-1:0] fixed_info();
        logic [N*W-1:0] v;
        v = '0;
        for (int h = 0; h < N; h++) v[h*W +: W] = W'(32'h10 + h);
        return v;
    endfunction

    function automatic logic [N*W-1:0] random_info();
        logic [N*W-1:0] v;
        for (int h = 0; h < N*W/32; h++) v[h*32 +: 32] = $urandom;
        return v;
    endfunction

    // Pick the host that should be granted: first valid host with credit left,
    // scanning from the pointer.
    function automatic int model_pick(input logic [N-1:0] v);
`ifdef JOB_ARB_HOST0_PRIO_EN
        if (v[0] && m_credit[0] > 0) return 0;
`endif
        for (int k = 0; k < N; k++) begin
            int h;
            h = (m_ptr + k) % N;
`ifdef JOB_ARB_HOST0_PRIO_EN
            if (h == 0) continue;
`endif
            if (v[h] && m_credit[h] > 0) return h;
        end
        return -1;
    endfunction

    function automatic logic [N-1:0] model_avail();
        logic [N-1:0] a;
        for (int h = 0; h < N; h++) a[h] = (m_credit[h] > 0);
        return a;
    endfunction

    task automatic model_reset();
        for (int h = 0; h < N; h++) m_credit[h] = TAG;
        m_ptr  = 0;
        m_info = '0;
        m_req  = 0;
        m_id   = 0;
        m_err  = 0;
    endtask

    // One clock of traffic. Registered outputs from the previous edge are
    // checked first. Then new inputs are driven, the combinational outputs are
    // checked, and the model is advanced to the next edge.
    task automatic step(input logic [N-1:0] v, input bit dv, input int dh,
                        input logic [N*W-1:0] inf);
        int g;
        logic [N-1:0] exp_ready;
        @(negedge clk);
        chk("info_req", 128'(info_req), 128'(m_req));
        chk("host_id", 128'(host_id), 128'(m_id));
        chk("info", 128'(info), 128'(m_info));
        chk("credit_err", 128'(credit_err), 128'(m_err));
        req_valid    = v;
        req_info     = inf;
        done_valid   = dv;
        done_host_id = HW'(dh);
        #1;
        g = model_pick(v);
        exp_ready = (g >= 0) ? (N'(1) << g) : '0;
        chk("req_ready", 128'(req_ready), 128'(exp_ready));
        chk("credit_avail", 128'(credit_avail), 128'(model_avail()));
        if (dv) begin
            if (dh >= N) m_err = 1;
            else if (dh != g) begin
                if (m_credit[dh] == TAG) m_err = 1;
                else m_credit[dh]++;
            end
        end
        if (g >= 0) begin
            if (!(dv && dh == g)) m_credit[g]--;
            m_info = inf[g*W +: W];
            m_id   = g;
            m_req  = 1;
            grant_count++;
`ifdef JOB_ARB_HOST0_PRIO_EN
            if (g != 0) m_ptr = (g + 1) % N;
`else
            m_ptr = (g + 1) % N;
`endif
        end else begin
            m_req = 0;
        end
    endtask

    // Assert reset a couple of ns after an edge, so it lands mid-cycle.
    task automatic do_reset();
        req_valid  = '0;
        done_valid = 1'b0;
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        chk("rst_info_req", 128'(info_req), 128'(0));
        chk("rst_host_id", 128'(host_id), 128'(0));
        chk("rst_info", 128'(info), 128'(0));
        chk("rst_err", 128'(credit_err), 128'(0));
        chk("rst_avail", 128'(credit_avail), 128'({N{1'b1}}));
        chk("rst_ready", 128'(req_ready), 128'(0));
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        n_checks     = 0;
        n_fail       = 0;
        grant_count  = 0;
        rst_n        = 1'b1;
        req_valid    = '0;
        req_info     = '0;
        done_valid   = 1'b0;
        done_host_id = '0;
        model_reset();
        #3;
        do_reset();

        // 1: all hosts valid until every credit is gone.
        grant_count = 0;
        for (int i = 0; i < 18; i++) step(4'b1111, 0, 0, fixed_info());
        chk("t1_grants", 128'(grant_count), 128'(16));
        chk("t1_avail_empty", 128'(credit_avail), 128'(0));

        // 2: host 2 alone. One done gives back exactly one more grant.
        do_reset();
        grant_count = 0;
        for (int i = 0; i < 5; i++) step(4'b0100, 0, 0, fixed_info());
        step(4'b0100, 1, 2, fixed_info());
        for (int i = 0; i < 3; i++) step(4'b0100, 0, 0, fixed_info());
        chk("t2_grants", 128'(grant_count), 128'(5));

        // 3: host 1 at credit 1. A grant and a done in the same cycle.
        do_reset();
        for (int i = 0; i < 3; i++) step(4'b0010, 0, 0, fixed_info());
        step(4'b0010, 1, 1, fixed_info());
        step(4'b0010, 0, 0, fixed_info());
        step(4'b0000, 0, 0, fixed_info());

        // 4: a done at full credit sets a sticky error.
        do_reset();
        step(4'b0000, 1, 0, fixed_info());
        for (int i = 0; i < 3; i++) step(4'b0000, 0, 0, fixed_info());
        chk("t4_err_sticky", 128'(credit_err), 128'(1));
        chk("t4_avail", 128'(credit_avail), 128'(4'b1111));

        // 5: reset in the middle of a burst, while a pulse is pending.
        do_reset();
        for (int i = 0; i < 3; i++) step(4'b1111, 0, 0, fixed_info());
        chk("t5_pulse_before", 128'(info_req), 128'(1));
        do_reset();
        for (int i = 0; i < 3; i++) step(4'b1111, 0, 0, fixed_info());

        // 6: hosts 0 and 3 compete.
        do_reset();
        for (int i = 0; i < 8; i++) step(4'b1001, 0, 0, fixed_info());

        // Random traffic. Completions mostly go to hosts with tags outstanding.
        do_reset();
        for (int i = 0; i < 400; i++) begin
            logic [N-1:0] v;
            bit dv;
            int dh;
            v  = N'($urandom);
            dh = int'($urandom_range(0, N - 1));
            dv = ($urandom_range(0, 2) == 0);
            if (dv && m_credit[dh] == TAG && $urandom_range(0, 19) != 0) dv = 0;
            step(v, dv, dh, random_info());
        end
        step(4'b0000, 0, 0, '0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
